retospect_bs_loader: RTL and testbench
======================================

# retospect_bs_loader

Byte-wide configuration loader for the neurochip fabric. It sits directly upstream of the serial configuration chain (clockbox followed by the cell array). It accepts configuration bytes over a valid/ready handshake and serialises them LSB-first onto the chain's `bs_in` while asserting `config_en`. It then checks a trailing CRC-8 byte and issues a one-cycle `reset_nn` pulse that arms the network.

## Interface

**Parameters**
- `CHAIN_BITS`, default 948: total chain length (6×8 clockbox bits + 50 cells × 18 bits).
- `CRC_POLY`, default 8'h07: CRC-8 polynomial.

**Ports**
- `clk`, input, 1: single clock shared with the fabric.
- `rst_n`, input, 1: reset, asynchronous and active-low; clears all state.
- `start`, input, 1: single-cycle request to begin a load; honoured only in IDLE.
- `byte_in`, input, 8: configuration or CRC byte.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: loader accepts a byte this cycle.
- `config_en`, output, 1: chain shift enable.
- `bs_out`, output, 1: serial bit into the chain's `bs_in`.
- `reset_nn`, output, 1: one-cycle network re-arm pulse.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: sticky; load complete.
- `crc_ok`, output, 1: sticky; valid together with `done`.

## Operation

**States**
- IDLE: `byte_ready`=0.
  - On `start`: clear bit counter, CRC register, `done` and `crc_ok`; go to FETCH.
- FETCH: `byte_ready`=1.
  - On `byte_valid`: latch `byte_in` into the shift register, set the per-byte count, go to SHIFT.
  - Per-byte count is 8, or `CHAIN_BITS` − bits_sent if fewer than 8 chain bits remain.
- SHIFT: `config_en`=1, `bs_out`=shreg[0] on every cycle.
  - Each cycle: shift shreg right, increment bits_sent, update the CRC with the emitted bit.
  - When the per-byte count is exhausted: go to CHECK if bits_sent = `CHAIN_BITS`, otherwise to FETCH.
- CHECK: `byte_ready`=1.
  - On `byte_valid`: set `crc_ok` = (`byte_in` == crc); set `done`=1; go to ARM if they match, otherwise IDLE.
- ARM: `reset_nn`=1 for exactly one cycle, then IDLE.

**Bit and CRC rules**
- Bit order: byte LSB first, bytes in arrival order. The first bit sent ends at the far end of the chain.
- Unused upper bits of a final partial byte are discarded: not shifted, not CRC'd.
- CRC-8 is MSB-first serial, init 8'h00, no final XOR.
- Per emitted bit b: fb = crc[7]^b; crc ← {crc[6:0],0} ^ (fb ? `CRC_POLY` : 0).
- bits_sent width: $clog2(`CHAIN_BITS`+1). It never exceeds `CHAIN_BITS`, and there is no wrap.

**Output rules**
- `bs_out` is 0 whenever `config_en`=0.
- `config_en` is never high outside SHIFT.
- `start` outside IDLE is ignored.
- `byte_valid` while `byte_ready`=0 is ignored; the byte is not consumed.
- CRC mismatch: `done`=1, `crc_ok`=0, and no `reset_nn` pulse. The chain contents are undefined and the host must reload.
- `rst_n` low mid-load: `config_en` and `reset_nn` drop asynchronously, state returns to IDLE, and the partial chain load is abandoned.

## Timing

**Reset values**
- All outputs are 0 while `rst_n`=0: `byte_ready`, `config_en`, `bs_out`, `reset_nn`, `busy`, `done`, `crc_ok`.

**Latency**
- `start` to `byte_ready`: high in the next cycle.
- Byte acceptance is a cycle with `byte_valid`&&`byte_ready`.
- SHIFT begins the cycle after acceptance and lasts exactly n cycles, where n is the per-byte count.
- `byte_ready` is low throughout SHIFT; there is no overlap.
- A full byte therefore costs at least 9 cycles.
- Default load, with an always-valid host: 119 fetch cycles + 948 shift cycles + 1 CHECK acceptance cycle + 1 ARM cycle.

**Output sequencing**
- `reset_nn` is high the cycle after CRC acceptance.
- `done` and `crc_ok` update in the same cycle as the CRC acceptance edge, so they read as 1 from that cycle's following edge.
- `busy` falls the cycle after ARM, or after CHECK on a mismatch.
- All outputs are registered; there are no combinational paths from input to output.

## Structure

**Package `retospect_bs_pkg`**
- State enum: IDLE, FETCH, SHIFT, CHECK, ARM.
- Default `CRC_POLY`.
- Default `CHAIN_BITS`, derived from the clockbox and cell bit counts (48 and 18) and the array size.

**Sub-module `retospect_crc8_serial`**
- Ports: clk, rst_n, clr, en, bit_in, crc[7:0].
- Reused later for readback checking.

## Test plan

1. `CHAIN_BITS`=16, `start`, bytes 8'hA5, 8'h3C, then the correct CRC:
   - `config_en` is high for exactly 16 cycles.
   - `bs_out` sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0.
   - `done`=1, `crc_ok`=1, and `reset_nn` pulses once.
2. `CHAIN_BITS`=12, bytes 8'hFF, 8'hFF:
   - The second byte emits only 4 bits.
   - The CRC is computed over 12 ones.
   - `config_en` is high for 12 cycles total.
3. Wrong CRC byte (correct ^ 8'h01):
   - `done`=1, `crc_ok`=0.
   - `reset_nn` never asserts; returns to IDLE.
4. Host inserts random `byte_valid` gaps, and pulses `start` and `byte_valid` during SHIFT:
   - Bits and CRC are unchanged.
   - No extra byte is consumed.
   - The second `start` is ignored.
5. `rst_n` asserted in the middle of the 5th shift cycle:
   - All outputs are 0 immediately.
   - A following clean load with the default `CHAIN_BITS`=948 succeeds.
   - Chained with a cell-array model, its `bs_out` equals the loaded stream delayed 948 cycles.
6. Back-to-back loads: a second `start` after `done`:
   - `done` and `crc_ok` clear on `start`.
   - The CRC restarts from 8'h00.

Source files
------------

// File: rtl/retospect_bs_pkg.sv
// rtl/retospect_bs_pkg.sv - shared types, defaults and CRC step for the bitstream loader
package retospect_bs_pkg;

  localparam int CLOCKBOX_BITS = 48;
  localparam int CELL_BITS     = 18;
  localparam int NUM_CELLS     = 50;

  // Full chain: clockbox registers first, then the cell array.
  localparam int         DEFAULT_CHAIN_BITS = CLOCKBOX_BITS + CELL_BITS * NUM_CELLS;
  localparam logic [7:0] DEFAULT_CRC_POLY   = 8'h07;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    ARM   = 3'd4
  } state_t;

  // One MSB-first serial CRC-8 step.
  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc_in,
    input logic       bit_in,
    input logic [7:0] poly
  );
    logic fb;
    fb = crc_in[7] ^ bit_in;
    return {crc_in[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/retospect_crc8_serial.sv
// rtl/retospect_crc8_serial.sv - bit-serial CRC-8 accumulator, init 0, no final xor
module retospect_crc8_serial
  import retospect_bs_pkg::*;
#(
  parameter logic [7:0] POLY = DEFAULT_CRC_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in, POLY);
    end
  end

endmodule

// File: rtl/retospect_bs_loader.sv
// rtl/retospect_bs_loader.sv - byte-wide loader serialising config bytes onto the chain
module retospect_bs_loader
  import retospect_bs_pkg::*;
#(
  parameter int         CHAIN_BITS = DEFAULT_CHAIN_BITS,
  parameter logic [7:0] CRC_POLY   = DEFAULT_CRC_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       config_en,
  output logic       bs_out,
  output logic       reset_nn,
  output logic       busy,
  output logic       done,
  output logic       crc_ok
);

  localparam int BW = $clog2(CHAIN_BITS + 1);

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_shreg;
  logic [3:0]      r_cnt;
  logic [BW-1:0]   r_bits_sent;
  logic            r_done;
  logic            r_crc_ok;

  logic [7:0]      w_crc;
  logic [31:0]     w_remain;
  logic [3:0]      w_first_cnt;
  logic            w_start_go;
  logic            w_shift_en;
  logic            w_last_bit;
  logic            w_chain_full;
  logic            w_crc_match;

  assign w_start_go   = (r_state == IDLE) && start;
  assign w_shift_en   = (r_state == SHIFT);
  assign w_last_bit   = (r_cnt == 4'd1);
  assign w_chain_full = ((32'(r_bits_sent) + 32'd1) == 32'(CHAIN_BITS));
  assign w_crc_match  = (byte_in == w_crc);

  // The final byte may carry fewer than 8 chain bits; its upper bits are dropped.
  assign w_remain    = 32'(CHAIN_BITS) - 32'(r_bits_sent);
  assign w_first_cnt = (w_remain < 32'd8) ? w_remain[3:0] : 4'd8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)      w_next = FETCH;
      FETCH:   if (byte_valid) w_next = SHIFT;
      SHIFT:   if (w_last_bit) w_next = w_chain_full ? CHECK : FETCH;
      CHECK:   if (byte_valid) w_next = w_crc_match ? ARM : IDLE;
      ARM:                     w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    config_en  = 1'b0;
    bs_out     = 1'b0;
    reset_nn   = 1'b0;
    busy       = (r_state != IDLE);
    case (r_state)
      FETCH, CHECK: byte_ready = 1'b1;
      SHIFT: begin
        config_en = 1'b1;
        bs_out    = r_shreg[0];
      end
      ARM:     reset_nn = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= 8'h00;
      r_cnt       <= 4'd0;
      r_bits_sent <= '0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
    end else begin
      if (w_start_go) begin
        r_bits_sent <= '0;
        r_done      <= 1'b0;
        r_crc_ok    <= 1'b0;
      end
      if ((r_state == FETCH) && byte_valid) begin
        r_shreg <= byte_in;
        r_cnt   <= w_first_cnt;
      end
      if (w_shift_en) begin
        r_shreg     <= {1'b0, r_shreg[7:1]};
        r_cnt       <= r_cnt - 4'd1;
        r_bits_sent <= r_bits_sent + BW'(1);
      end
      if ((r_state == CHECK) && byte_valid) begin
        r_crc_ok <= w_crc_match;
        r_done   <= 1'b1;
      end
    end
  end

  assign done   = r_done;
  assign crc_ok = r_crc_ok;

  retospect_crc8_serial #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_start_go),
    .en     (w_shift_en),
    .bit_in (r_shreg[0]),
    .crc    (w_crc)
  );

endmodule

// File: tb/tb_retospect_bs_loader.sv
// tb/tb_retospect_bs_loader.sv - randomized self-checking bench for retospect_bs_loader
`timescale 1ns/1ps
module tb_retospect_bs_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] bvalid_v;
  logic [7:0] byte_in_v [3];
  logic [2:0] ready_v, cen_v, bs_v, rnn_v, busy_v, done_v, crcok_v;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic [7:0] tx_bytes [$];
  bit         exp_bits [$];
  bit         obs_bits [$];
  logic [7:0] exp_crc;

  bit mon_on = 0;
  int rnn_cnt, acc_cnt, busy_cnt, proto_err;

  logic [947:0] chain;

  retospect_bs_loader #(.CHAIN_BITS(16), .CRC_POLY(8'h07)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .byte_in(byte_in_v[0]),
    .byte_valid(bvalid_v[0]), .byte_ready(ready_v[0]), .config_en(cen_v[0]),
    .bs_out(bs_v[0]), .reset_nn(rnn_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .crc_ok(crcok_v[0])
  );

  retospect_bs_loader #(.CHAIN_BITS(12), .CRC_POLY(8'h07)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .byte_in(byte_in_v[1]),
    .byte_valid(bvalid_v[1]), .byte_ready(ready_v[1]), .config_en(cen_v[1]),
    .bs_out(bs_v[1]), .reset_nn(rnn_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .crc_ok(crcok_v[1])
  );

  retospect_bs_loader u_dut948 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .byte_in(byte_in_v[2]),
    .byte_valid(bvalid_v[2]), .byte_ready(ready_v[2]), .config_en(cen_v[2]),
    .bs_out(bs_v[2]), .reset_nn(rnn_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .crc_ok(crcok_v[2])
  );

  // Cell-array model: bits enter at the near end and walk to the far end.
  always @(negedge clk) begin
    if (cen_v[2]) chain <= {chain[946:0], bs_v[2]};
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (cen_v[sel]) obs_bits.push_back(bs_v[sel]);
      if (rnn_v[sel]) rnn_cnt++;
      if (busy_v[sel]) busy_cnt++;
      if (bvalid_v[sel] && ready_v[sel]) acc_cnt++;
      if ((!cen_v[sel] && bs_v[sel]) || (cen_v[sel] && ready_v[sel])) proto_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int nb);
    tx_bytes.delete();
    for (int i = 0; i < nb; i++) tx_bytes.push_back(8'($urandom));
  endtask

  // Expected stream: chain bit i is bit (i mod 8) of byte i/8; CRC over exactly those bits.
  task automatic build_model(input int cb);
    logic [7:0] b;
    bit v, fb;
    exp_bits.delete();
    exp_crc = 8'h00;
    for (int i = 0; i < cb; i++) begin
      b = tx_bytes[i / 8];
      v = b[i % 8];
      exp_bits.push_back(v);
      fb = exp_crc[7] ^ v;
      exp_crc = {exp_crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
  endtask

  task automatic host_load(input int cb, input int gap_max, input bit noise, input bit bad_crc);
    int nb, wait_cnt, nmis, exp_busy;
    bit to, first, good;
    logic [7:0] b;
    nb   = (cb + 7) / 8;
    good = !bad_crc;
    build_model(cb);
    obs_bits.delete();
    rnn_cnt = 0; acc_cnt = 0; busy_cnt = 0; proto_err = 0;
    mon_on = 1; to = 0; first = 1;
    tick(); start_v[sel] = 1'b1;
    tick(); start_v[sel] = 1'b0;
    for (int k = 0; k <= nb; k++) begin
      b = (k < nb) ? tx_bytes[k] : (exp_crc ^ {7'd0, bad_crc});
      if (k > 0) repeat ($urandom_range(gap_max, 0)) tick();
      byte_in_v[sel] = b;
      bvalid_v[sel]  = 1'b1;
      wait_cnt = 0;
      forever begin
        @(negedge clk);
        if (first) begin
          first = 0;
          checks++;
          if ({ready_v[sel], done_v[sel], crcok_v[sel]} !== 3'b100) begin
            errors++;
            $display("FAIL start_response: ready,done,crc_ok got %b want 100",
                     {ready_v[sel], done_v[sel], crcok_v[sel]});
          end
        end
        if (ready_v[sel]) break;
        wait_cnt++;
        if (wait_cnt > 64) break;
      end
      if (!ready_v[sel]) begin
        to = 1;
        bvalid_v[sel] = 1'b0;
        break;
      end
      tick();
      bvalid_v[sel] = 1'b0;
      if (noise && k < nb) begin
        tick();
        start_v[sel]   = 1'b1;
        bvalid_v[sel]  = 1'b1;
        byte_in_v[sel] = 8'($urandom);
        tick();
        start_v[sel]   = 1'b0;
        bvalid_v[sel]  = 1'b0;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL handshake_timeout: byte %0d not accepted, timeout got 1 want 0", acc_cnt);
    end
    @(negedge clk);
    checks++;
    if ({done_v[sel], crcok_v[sel], rnn_v[sel], busy_v[sel]} !== {1'b1, good, good, good}) begin
      errors++;
      $display("FAIL after_crc: done,crc_ok,reset_nn,busy got %b want %b",
               {done_v[sel], crcok_v[sel], rnn_v[sel], busy_v[sel]}, {1'b1, good, good, good});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({rnn_v[sel], busy_v[sel], done_v[sel], crcok_v[sel]} !== {1'b0, 1'b0, 1'b1, good}) begin
      errors++;
      $display("FAIL settle: reset_nn,busy,done,crc_ok got %b want %b",
               {rnn_v[sel], busy_v[sel], done_v[sel], crcok_v[sel]}, {1'b0, 1'b0, 1'b1, good});
    end
    mon_on = 0;
    nmis = 0;
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++)
      if (obs_bits[i] !== exp_bits[i]) nmis++;
    checks++;
    if (obs_bits.size() != cb) begin
      errors++;
      $display("FAIL config_en_cycles: got %0d want %0d", obs_bits.size(), cb);
    end
    checks++;
    if (nmis != 0) begin
      errors++;
      $display("FAIL bs_stream: mismatching bits got %0d want 0", nmis);
    end
    checks++;
    if (rnn_cnt != int'(good)) begin
      errors++;
      $display("FAIL reset_nn_pulses: got %0d want %0d", rnn_cnt, int'(good));
    end
    checks++;
    if (acc_cnt != nb + 1) begin
      errors++;
      $display("FAIL bytes_consumed: got %0d want %0d", acc_cnt, nb + 1);
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL output_rules: violations got %0d want 0", proto_err);
    end
    if (gap_max == 0) begin
      exp_busy = nb + cb + 1 + int'(good);
      checks++;
      if (busy_cnt != exp_busy) begin
        errors++;
        $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, exp_busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready_v, cen_v, bs_v, rnn_v, busy_v, done_v, crcok_v} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {ready_v, cen_v, bs_v, rnn_v, busy_v, done_v, crcok_v});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic16();
    logic [15:0] v;
    sel = 0;
    tx_bytes.delete();
    tx_bytes.push_back(8'hA5);
    tx_bytes.push_back(8'h3C);
    host_load(16, 0, 0, 0);
    v = '0;
    for (int i = 0; i < obs_bits.size() && i < 16; i++) v[i] = obs_bits[i];
    checks++;
    if (v !== 16'h3CA5) begin
      errors++;
      $display("FAIL basic16_sequence: got %h want 3ca5", v);
    end
  endtask

  task automatic test_partial12();
    sel = 1;
    tx_bytes.delete();
    tx_bytes.push_back(8'hFF);
    tx_bytes.push_back(8'hFF);
    host_load(12, 0, 0, 0);
  endtask

  task automatic test_bad_crc();
    sel = 1;
    fill_random(2);
    host_load(12, 0, 0, 1);
    sel = 0;
    fill_random(2);
    host_load(16, 2, 0, 1);
  endtask

  task automatic test_noise();
    for (int r = 0; r < 3; r++) begin
      sel = r % 2;
      fill_random(2);
      host_load((r % 2 == 0) ? 16 : 12, 4, 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    for (int r = 0; r < 3; r++) begin
      fill_random(2);
      host_load(16, 0, r == 1, 0);
    end
  endtask

  task automatic test_reset_mid_load();
    int wait_cnt;
    logic [947:0] exp_chain;
    logic was_shifting;
    sel = 2;
    fill_random(119);
    tick(); start_v[2] = 1'b1;
    tick(); start_v[2] = 1'b0;
    byte_in_v[2] = tx_bytes[0];
    bvalid_v[2]  = 1'b1;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (cen_v[2] || wait_cnt > 20) break;
      wait_cnt++;
    end
    repeat (4) @(negedge clk);
    was_shifting = cen_v[2];
    rst_n = 1'b0;
    bvalid_v[2] = 1'b0;
    #1;
    checks++;
    if ({was_shifting, ready_v[2], cen_v[2], bs_v[2], rnn_v[2], busy_v[2], done_v[2], crcok_v[2]}
        !== 8'b1000_0000) begin
      errors++;
      $display("FAIL mid_load_reset: shifting,ready,cen,bs,rnn,busy,done,crc_ok got %b want 10000000",
               {was_shifting, ready_v[2], cen_v[2], bs_v[2], rnn_v[2], busy_v[2], done_v[2], crcok_v[2]});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fill_random(119);
    host_load(948, 0, 0, 0);
    exp_chain = '0;
    for (int i = 0; i < 948 && i < exp_bits.size(); i++) exp_chain[947 - i] = exp_bits[i];
    checks++;
    if (chain !== exp_chain) begin
      errors++;
      $display("FAIL chain_contents: far end bits got %h want %h", chain[947:916], exp_chain[947:916]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start_v   = '0;
    bvalid_v  = '0;
    for (int i = 0; i < 3; i++) byte_in_v[i] = 8'h00;
    test_reset();
    test_basic16();
    test_partial12();
    test_bad_crc();
    test_noise();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
